// File: rtl/mem_arbiter.sv
// mem_arbiter: shared SRAM arbiter between instruction fetch and MEM data port.
// Optional MEM_ARB_RD_WAIT_EN adds one RD_WAIT cycle to every read.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stall_req_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_wdata_en_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
`ifdef MEM_ARB_RD_WAIT_EN
        S_RD_WAIT,
`endif
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_ACK
    } state_t;

    state_t state;
    logic   owner_mem;

    // Pipeline stalls while any request has not yet been acknowledged.
    assign stall_req_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

    // Arbitration FSM; strobes, address, data and acks are all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            owner_mem      <= 1'b0;
            if_ack_o       <= 1'b0;
            mem_ack_o      <= 1'b0;
            if_rdata_o     <= '0;
            mem_rdata_o    <= '0;
            ram_ce_n_o     <= 1'b1;
            ram_oe_n_o     <= 1'b1;
            ram_we_n_o     <= 1'b1;
            ram_addr_o     <= '0;
            ram_wdata_o    <= '0;
            ram_wdata_en_o <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    ram_ce_n_o     <= 1'b1;
                    ram_oe_n_o     <= 1'b1;
                    ram_we_n_o     <= 1'b1;
                    ram_wdata_en_o <= 1'b0;
                    if (mem_req_i) begin
                        owner_mem   <= 1'b1;
                        ram_addr_o  <= mem_addr_i;
                        ram_wdata_o <= mem_wdata_i;
                        ram_ce_n_o  <= 1'b0;
                        if (mem_we_i) begin
                            ram_wdata_en_o <= 1'b1;
                            state          <= S_WR_SETUP;
                        end else begin
                            ram_oe_n_o <= 1'b0;
                            state      <= S_RD;
                        end
                    end else if (if_req_i) begin
                        owner_mem  <= 1'b0;
                        ram_addr_o <= if_addr_i;
                        ram_ce_n_o <= 1'b0;
                        ram_oe_n_o <= 1'b0;
                        state      <= S_RD;
                    end
                end
`ifdef MEM_ARB_RD_WAIT_EN
                S_RD: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (owner_mem) begin
                        mem_rdata_o <= ram_rdata_i;
                        mem_ack_o   <= 1'b1;
                    end else begin
                        if_rdata_o <= ram_rdata_i;
                        if_ack_o   <= 1'b1;
                    end
                    ram_ce_n_o <= 1'b1;
                    ram_oe_n_o <= 1'b1;
                    state      <= S_ACK;
                end
`else
                S_RD: begin
                    if (owner_mem) begin
                        mem_rdata_o <= ram_rdata_i;
                        mem_ack_o   <= 1'b1;
                    end else begin
                        if_rdata_o <= ram_rdata_i;
                        if_ack_o   <= 1'b1;
                    end
                    ram_ce_n_o <= 1'b1;
                    ram_oe_n_o <= 1'b1;
                    state      <= S_ACK;
                end
`endif
                S_WR_SETUP: begin
                    ram_we_n_o <= 1'b0;
                    state      <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    ram_we_n_o <= 1'b1;
                    state      <= S_WR_HOLD;
                end
                S_WR_HOLD: begin
                    ram_ce_n_o     <= 1'b1;
                    ram_wdata_en_o <= 1'b0;
                    mem_ack_o      <= 1'b1;
                    state          <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter timing, priority and reset.
// Honours MEM_ARB_RD_WAIT_EN for the expected read latency.
module tb_mem_arbiter;

`ifdef MEM_ARB_RD_WAIT_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        wdata_en;
    logic [15:0] ram_rdata;

    logic [15:0] sram [0:65535];

    int n_checks = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_ack_o       (if_ack),
        .if_rdata_o     (if_rdata),
        .mem_req_i      (mem_req),
        .mem_we_i       (mem_we),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .mem_ack_o      (mem_ack),
        .mem_rdata_o    (mem_rdata),
        .stall_req_o    (stall),
        .ram_ce_n_o     (ce_n),
        .ram_oe_n_o     (oe_n),
        .ram_we_n_o     (we_n),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_wdata_en_o (wdata_en),
        .ram_rdata_i    (ram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: preload while in reset, write while ce_n and we_n are low.
    always @(posedge clk) begin
        if (!rst_n) begin
            sram[16'h0010] <= 16'h4A05;
            sram[16'h0001] <= 16'h1111;
            sram[16'h0200] <= 16'h2222;
        end else if (!ce_n && !we_n) begin
            sram[ram_addr] <= ram_wdata;
        end
    end

    assign ram_rdata = sram[ram_addr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input bit is_mem, input logic [15:0] a,
                      input logic [15:0] exp);
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1;
            mem_we = 1'b0;
            mem_addr = a;
        end else begin
            if_req = 1'b1;
            if_addr = a;
        end
        #1;
        check("rd_stall_pre", 32'(stall), 1);
        @(negedge clk);
        check("rd_strobes", 32'({ce_n, oe_n, we_n}), 1);
        check("rd_addr", 32'(ram_addr), 32'(a));
        check("rd_no_early_ack", 32'(if_ack | mem_ack), 0);
        mem_addr = ~a;
        if_addr = ~a;
        for (int i = 2; i < RD_LAT; i++) begin
            @(negedge clk);
            check("rd_wait_ack", 32'(if_ack | mem_ack), 0);
            check("rd_wait_strobes", 32'({ce_n, oe_n, we_n}), 1);
        end
        @(negedge clk);
        if (is_mem) begin
            check("mem_ack", 32'(mem_ack), 1);
            check("mem_rdata", 32'(mem_rdata), 32'(exp));
            check("mem_other_ack", 32'(if_ack), 0);
        end else begin
            check("if_ack", 32'(if_ack), 1);
            check("if_rdata", 32'(if_rdata), 32'(exp));
            check("if_other_ack", 32'(mem_ack), 0);
        end
        check("rd_stall_ack", 32'(stall), 0);
        check("rd_ack_strobes", 32'({ce_n, oe_n, we_n}), 7);
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = a;
        mem_wdata = d;
        #1;
        check("wr_stall_pre", 32'(stall), 1);
        @(negedge clk);
        check("wr_setup_strobes", 32'({ce_n, oe_n, we_n}), 3);
        check("wr_setup_en", 32'(wdata_en), 1);
        check("wr_setup_addr", 32'(ram_addr), 32'(a));
        check("wr_setup_data", 32'(ram_wdata), 32'(d));
        mem_addr = ~a;
        mem_wdata = ~d;
        @(negedge clk);
        check("wr_pulse_strobes", 32'({ce_n, oe_n, we_n}), 2);
        check("wr_pulse_addr", 32'(ram_addr), 32'(a));
        check("wr_pulse_data", 32'(ram_wdata), 32'(d));
        check("wr_pulse_ack", 32'(mem_ack), 0);
        @(negedge clk);
        check("wr_hold_strobes", 32'({ce_n, oe_n, we_n}), 3);
        check("wr_hold_en", 32'(wdata_en), 1);
        check("wr_hold_addr", 32'(ram_addr), 32'(a));
        check("wr_hold_data", 32'(ram_wdata), 32'(d));
        check("wr_hold_ack", 32'(mem_ack), 0);
        @(negedge clk);
        check("wr_ack", 32'(mem_ack), 1);
        check("wr_ack_strobes", 32'({ce_n, oe_n, we_n}), 7);
        check("wr_ack_en", 32'(wdata_en), 0);
        check("wr_stall_ack", 32'(stall), 0);
        mem_req = 1'b0;
        mem_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({ce_n, oe_n, we_n}), 7);
        check("rst_en", 32'(wdata_en), 0);
        check("rst_acks", 32'({if_ack, mem_ack}), 0);
        check("rst_if_rdata", 32'(if_rdata), 0);
        check("rst_mem_rdata", 32'(mem_rdata), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_wdata", 32'(ram_wdata), 0);
        check("rst_stall", 32'(stall), 0);
        rst_n = 1'b1;
        @(negedge clk);

        rd(1'b0, 16'h0010, 16'h4A05);

        wr(16'h8000, 16'hBEEF);
        rd(1'b1, 16'h8000, 16'hBEEF);
        check("if_rdata_kept", 32'(if_rdata), 32'h4A05);
        wr(16'h0020, 16'h5555);
        check("mem_rdata_after_wr", 32'(mem_rdata), 32'hBEEF);

        // Simultaneous IF and MEM requests: MEM wins.
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 16'h0001;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 16'h0200;
        @(negedge clk);
        check("sim_mem_first", 32'(ram_addr), 32'h0200);
        repeat (RD_LAT - 1) @(negedge clk);
        check("sim_mem_ack", 32'(mem_ack), 1);
        check("sim_if_wait", 32'(if_ack), 0);
        check("sim_mem_rdata", 32'(mem_rdata), 32'h2222);
        check("sim_if_untouched", 32'(if_rdata), 32'h4A05);
        check("sim_stall", 32'(stall), 1);
        mem_req = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            @(negedge clk);
            check("sim_if_not_yet", 32'(if_ack), 0);
        end
        @(negedge clk);
        check("sim_if_ack", 32'(if_ack), 1);
        check("sim_if_rdata", 32'(if_rdata), 32'h1111);
        check("sim_mem_kept", 32'(mem_rdata), 32'h2222);
        if_req = 1'b0;

        // Request held through ACK, dropped in IDLE: no second grant.
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 16'h0010;
        repeat (RD_LAT) @(negedge clk);
        check("hold_ack", 32'(if_ack), 1);
        @(negedge clk);
        check("hold_no_grant_in_ack", 32'(ce_n), 1);
        check("hold_ack_single", 32'(if_ack), 0);
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_idle_ce", 32'(ce_n), 1);
            check("hold_idle_ack", 32'(if_ack), 0);
        end

        // Request still high in IDLE: a second grant follows.
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 16'h0001;
        repeat (RD_LAT) @(negedge clk);
        check("regrant_first_ack", 32'(if_ack), 1);
        @(negedge clk);
        check("regrant_idle_ce", 32'(ce_n), 1);
        @(negedge clk);
        check("regrant_ce", 32'(ce_n), 0);
        repeat (RD_LAT - 1) @(negedge clk);
        check("regrant_ack", 32'(if_ack), 1);
        if_req = 1'b0;

        // Reset asserted during the write pulse.
        @(negedge clk);
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 16'h0040;
        mem_wdata = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        check("rstw_pulse", 32'(we_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_we_n", 32'(we_n), 1);
        check("rstw_en", 32'(wdata_en), 0);
        check("rstw_ce_n", 32'(ce_n), 1);
        check("rstw_ack", 32'(mem_ack), 0);
        check("rstw_addr", 32'(ram_addr), 0);
        check("rstw_if_rdata", 32'(if_rdata), 0);
        mem_req = 1'b0;
        mem_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_idle_ce", 32'(ce_n), 1);
            check("rstw_no_ack", 32'(mem_ack), 0);
        end
        rd(1'b1, 16'h8000, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared SRAM between the instruction-fetch port and the MEM-stage data port of the 16-bit pipeline. It sequences SRAM read and write cycles through a small FSM and returns data with a one-cycle acknowledge. It raises `stall_req` to the pipeline controller while any requester is waiting. MEM has fixed priority over IF.

## Interface
Parameters:
- `ADDR_W`, 16: SRAM word-address width.
- `DATA_W`, 16: data width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `if_req_i`  in  1  fetch request; held until `if_ack_o`.
- `if_addr_i`  in  ADDR_W  fetch address (`pc`).
- `if_ack_o`  out  1  one-cycle pulse; `if_rdata_o` valid this cycle.
- `if_rdata_o`  out  DATA_W  fetched instruction, registered.
- `mem_req_i`  in  1  data request; held until `mem_ack_o`.
- `mem_we_i`  in  1  1 = write, 0 = read.
- `mem_addr_i`  in  ADDR_W  data address.
- `mem_wdata_i`  in  DATA_W  write data.
- `mem_ack_o`  out  1  one-cycle completion pulse.
- `mem_rdata_o`  out  DATA_W  load data, registered.
- `stall_req_o`  out  1  `(if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)`, combinational.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1 each  SRAM strobes, all registered.
- `ram_addr_o`  out  ADDR_W  SRAM address, registered.
- `ram_wdata_o`  out  DATA_W  SRAM write data, registered.
- `ram_wdata_en_o`  out  1  write-data bus drive enable for the top-level tristate.
- `ram_rdata_i`  in  DATA_W  SRAM read data.

## Operation
States: IDLE, RD, (RD_WAIT), WR_SETUP, WR_PULSE, WR_HOLD, ACK.

- **IDLE**
  - All strobes high and `ram_wdata_en_o = 0`.
  - If `mem_req_i` is set, latch owner = MEM together with addr, we and wdata.
    - `mem_we_i = 1` goes to WR_SETUP.
    - `mem_we_i = 0` goes to RD.
  - Otherwise, if `if_req_i` is set, latch owner = IF and addr, then go to RD.
  - Otherwise stay in IDLE.
- **RD**
  - `ce_n = 0`, `oe_n = 0`, address driven.
  - At the end of the cycle, `ram_rdata_i` is captured into the owner's rdata register.
  - Next state: ACK.
- **WR_SETUP**
  - `ce_n = 0`, `we_n = 1`, `ram_wdata_en_o = 1`.
  - Next state: WR_PULSE.
- **WR_PULSE**: `we_n = 0`; the other signals are unchanged.
- **WR_HOLD**
  - `we_n = 1`; address and data are still driven (hold time).
  - Next state: ACK.
- **ACK**
  - Strobes high.
  - The owner's ack is 1 for exactly this cycle.
  - No new request is sampled. The requester drops req in this cycle or later.
  - Next state: IDLE.
- **Data persistence**: rdata registers keep their last value until the next read for that owner. A write never alters `mem_rdata_o`.
- **Priority**: a simultaneous IF and MEM request in IDLE grants MEM first. IF is granted on the next IDLE visit. IF is never starved, because MEM issues at most one request per instruction.
- **Latching**: address and data are latched at grant. Input changes after grant are ignored until ACK.

## Timing
- **Reset** (asynchronous, immediate, including mid-write):
  - state = IDLE.
  - `ram_ce_n_o = ram_oe_n_o = ram_we_n_o = 1`.
  - `ram_wdata_en_o = 0`.
  - Both acks = 0.
  - `if_rdata_o = mem_rdata_o = 0`.
  - `ram_addr_o = ram_wdata_o = 0`.
- **Read**: request asserted in IDLE at edge N → RD during N..N+1 → ack high during N+1..N+2. That is 2 cycles from grant to ack, or 3 cycles with RD_WAIT.
- **Write**: grant at edge N → ack during N+3..N+4. The `we_n` low pulse is exactly one cycle and is bracketed by one cycle of setup and one cycle of hold.
- **Back-to-back**: the minimum request-to-request grant spacing is read 3 cycles and write 5 cycles.
- **`stall_req_o`**: falls in the ack cycle of the last outstanding request.

## Configuration
- `MEM_ARB_RD_WAIT_EN`
  - Defined: RD is followed by one RD_WAIT cycle (strobes unchanged), and data is captured at the end of RD_WAIT. Read latency is 3 cycles from grant to ack.
  - Undefined: the RD_WAIT state is absent and data is captured at the end of RD.
- Write timing is identical in both builds.

## Test plan
- **IF read**:
  - Stimulus: SRAM[0x0010] = 0x4A05, IF request at 0x0010.
  - Required: `if_ack_o` 2 cycles after grant with `if_rdata_o = 0x4A05`; `stall_req_o` high until the ack cycle.
- **MEM write, then read**:
  - Stimulus: write 0xBEEF to 0x8000, then read 0x8000.
  - Required: `we_n` low for exactly 1 cycle, with addr and data stable from setup through hold. The read returns 0xBEEF.
- **Simultaneous requests**:
  - Stimulus: IF at 0x0001 and MEM read at 0x0200 asserted in the same cycle.
  - Required: `mem_ack_o` first, then `if_ack_o` 3 cycles later; `if_rdata_o` is unaffected by the MEM read.
- **Request held through ACK**:
  - Stimulus: keep `if_req_i` high during the ack cycle and drop it one cycle later.
  - Required: no second grant during ACK; a second IF grant follows only if req is still high in IDLE.
- **Reset mid-write**:
  - Stimulus: assert `rst` low during WR_PULSE.
  - Required: `ram_we_n_o = 1` and `ram_wdata_en_o = 0` immediately without waiting for a clock edge, no ack is issued, and the FSM is in IDLE after release.
- **`MEM_ARB_RD_WAIT_EN` defined**:
  - Stimulus: IF read at 0x0010.
  - Required: ack 3 cycles after grant; a write still completes in 4 cycles from grant.
